// File: rtl/imu_bias_filter.sv
// Gyro zero-rate bias calibration, bias subtraction and six-axis low-pass filter for the IMU front end.
// Define IMU_IIR_EN for the first-order IIR; otherwise the filter stage is a plain register.
module imu_bias_filter #(
  parameter int WIDTH       = 18,
  parameter int CAL_LOG2    = 6,
  parameter int ALPHA_SHIFT = 3
) (
  input  logic                    c50m,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] AccelX,
  input  logic signed [WIDTH-1:0] AccelY,
  input  logic signed [WIDTH-1:0] AccelZ,
  input  logic signed [WIDTH-1:0] GyroX,
  input  logic signed [WIDTH-1:0] GyroY,
  input  logic signed [WIDTH-1:0] GyroZ,
  input  logic                    DataValid,
  input  logic                    Recal,
  output logic signed [WIDTH-1:0] FiltAccelX,
  output logic signed [WIDTH-1:0] FiltAccelY,
  output logic signed [WIDTH-1:0] FiltAccelZ,
  output logic signed [WIDTH-1:0] FiltGyroX,
  output logic signed [WIDTH-1:0] FiltGyroY,
  output logic signed [WIDTH-1:0] FiltGyroZ,
  output logic                    FiltValid,
  output logic                    Calibrated
);

  // state  | meaning
  // ST_CAL | accumulating gyro samples over the calibration window, no output
  // ST_RUN | bias-corrected samples flow through stage and filter registers

  localparam int AW = WIDTH + CAL_LOG2;

  typedef enum logic {ST_CAL, ST_RUN} state_t;

  state_t                  r_state;
  logic                    r_dv_q;
  logic [CAL_LOG2-1:0]     r_cal_cnt;
  logic signed [AW-1:0]    r_acc  [3];
  logic signed [WIDTH-1:0] r_bias [3];
  logic signed [WIDTH-1:0] r_stg  [6];
  logic                    r_stg_vld;
  logic signed [WIDTH-1:0] r_y    [6];
`ifdef IMU_IIR_EN
  logic                    r_seed;
`endif

  logic                    w_accept;
  logic signed [WIDTH-1:0] w_x       [6];
  logic signed [AW-1:0]    w_acc_nxt [3];

  assign w_accept = DataValid & ~r_dv_q;

  // axis order: accel X/Y/Z at 0..2, gyro X/Y/Z at 3..5
  assign w_x[0] = AccelX;
  assign w_x[1] = AccelY;
  assign w_x[2] = AccelZ;
  assign w_x[3] = GyroX;
  assign w_x[4] = GyroY;
  assign w_x[5] = GyroZ;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_acc_nxt[i] = r_acc[i] + AW'(w_x[3+i]);
    end
  end

  assign FiltAccelX = r_y[0];
  assign FiltAccelY = r_y[1];
  assign FiltAccelZ = r_y[2];
  assign FiltGyroX  = r_y[3];
  assign FiltGyroY  = r_y[4];
  assign FiltGyroZ  = r_y[5];

  function automatic logic signed [WIDTH-1:0] sat_sub(input logic signed [WIDTH-1:0] a,
                                                      input logic signed [WIDTH-1:0] b);
    logic signed [WIDTH:0] d;
    d = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    if (d[WIDTH] != d[WIDTH-1]) begin
      return d[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
    return d[WIDTH-1:0];
  endfunction

`ifdef IMU_IIR_EN
  // y moves toward x by a fraction; the sum stays between x and y so WIDTH bits always suffice
  function automatic logic signed [WIDTH-1:0] iir_step(input logic signed [WIDTH-1:0] y,
                                                       input logic signed [WIDTH-1:0] x);
    logic signed [WIDTH:0] d;
    logic signed [WIDTH:0] s;
    d = {x[WIDTH-1], x} - {y[WIDTH-1], y};
    s = {y[WIDTH-1], y} + (d >>> ALPHA_SHIFT);
    return s[WIDTH-1:0];
  endfunction
`endif

  always_ff @(posedge c50m) begin
    if (reset) begin
      r_state    <= ST_CAL;
      r_dv_q     <= 1'b0;
      r_cal_cnt  <= '1;
      r_stg_vld  <= 1'b0;
      FiltValid  <= 1'b0;
      Calibrated <= 1'b0;
`ifdef IMU_IIR_EN
      r_seed     <= 1'b1;
`endif
      for (int i = 0; i < 3; i++) begin
        r_acc[i]  <= '0;
        r_bias[i] <= '0;
      end
      for (int i = 0; i < 6; i++) begin
        r_stg[i] <= '0;
        r_y[i]   <= '0;
      end
    end else begin
      r_dv_q    <= DataValid;
      FiltValid <= 1'b0;
      r_stg_vld <= 1'b0;
      if (Recal) begin
        // clearing r_stg_vld here squashes any sample already in the stage register
        r_state    <= ST_CAL;
        Calibrated <= 1'b0;
        r_cal_cnt  <= '1;
`ifdef IMU_IIR_EN
        r_seed     <= 1'b1;
`endif
        for (int i = 0; i < 3; i++) r_acc[i] <= '0;
      end else if (r_state == ST_CAL) begin
        if (w_accept) begin
          if (r_cal_cnt == '0) begin
            for (int i = 0; i < 3; i++) begin
              r_bias[i] <= WIDTH'(w_acc_nxt[i] >>> CAL_LOG2);
              r_acc[i]  <= '0;
            end
            r_cal_cnt  <= '1;
            r_state    <= ST_RUN;
            Calibrated <= 1'b1;
          end else begin
            for (int i = 0; i < 3; i++) r_acc[i] <= w_acc_nxt[i];
            r_cal_cnt <= r_cal_cnt - CAL_LOG2'(1);
          end
        end
      end else begin
        if (w_accept) begin
          for (int i = 0; i < 3; i++) begin
            r_stg[i]   <= w_x[i];
            r_stg[3+i] <= sat_sub(w_x[3+i], r_bias[i]);
          end
          r_stg_vld <= 1'b1;
        end
        if (r_stg_vld) begin
`ifdef IMU_IIR_EN
          for (int i = 0; i < 6; i++) begin
            r_y[i] <= r_seed ? r_stg[i] : iir_step(r_y[i], r_stg[i]);
          end
          r_seed <= 1'b0;
`else
          for (int i = 0; i < 6; i++) r_y[i] <= r_stg[i];
`endif
          FiltValid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_imu_bias_filter.sv
// Scoreboard bench for imu_bias_filter (CAL_LOG2=2); expectations follow IMU_IIR_EN when defined.
module tb_imu_bias_filter;

  typedef logic signed [17:0] s18_t;
  typedef struct packed {
    int               due;
    logic [5:0][17:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  s18_t ax = '0, ay = '0, az = '0, gx = '0, gy = '0, gz = '0;
  logic dv = 1'b0;
  logic recal = 1'b0;
  s18_t fax, fay, faz, fgx, fgy, fgz;
  logic fv, cal;

  s18_t o_v [6];
  assign o_v[0] = fax;
  assign o_v[1] = fay;
  assign o_v[2] = faz;
  assign o_v[3] = fgx;
  assign o_v[4] = fgy;
  assign o_v[5] = fgz;

  imu_bias_filter #(.WIDTH(18), .CAL_LOG2(2), .ALPHA_SHIFT(3)) dut (
    .c50m(clk), .reset(rst),
    .AccelX(ax), .AccelY(ay), .AccelZ(az),
    .GyroX(gx), .GyroY(gy), .GyroZ(gz),
    .DataValid(dv), .Recal(recal),
    .FiltAccelX(fax), .FiltAccelY(fay), .FiltAccelZ(faz),
    .FiltGyroX(fgx), .FiltGyroY(fgy), .FiltGyroZ(fgz),
    .FiltValid(fv), .Calibrated(cal)
  );

  always #10 clk = ~clk;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   fv_cnt = 0;
  exp_t q[$];
  int   last_e [6];
  int   cal_gx [4];
  int   cal_gy [4];
  int   cal_gz [4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect6(input int e0, e1, e2, e3, e4, e5);
    exp_t e;
    e.due  = cyc + 2;
    e.v[0] = 18'(e0); e.v[1] = 18'(e1); e.v[2] = 18'(e2);
    e.v[3] = 18'(e3); e.v[4] = 18'(e4); e.v[5] = 18'(e5);
    last_e = '{e0, e1, e2, e3, e4, e5};
    q.push_back(e);
  endtask

  task automatic send(input int a0, a1, a2, g0, g1, g2, input int hi, input int lo);
    ax = 18'(a0); ay = 18'(a1); az = 18'(a2);
    gx = 18'(g0); gy = 18'(g1); gz = 18'(g2);
    dv = 1'b1;
    repeat (hi) step();
    dv = 1'b0;
    repeat (lo) step();
  endtask

  task automatic do_recal();
    recal = 1'b1;
    step();
    recal = 1'b0;
    step();
  endtask

  task automatic do_cal();
    for (int i = 0; i < 4; i++) begin
      check("cal_low_before_accept", int'(cal), 0);
      send(0, 0, 0, cal_gx[i], cal_gy[i], cal_gz[i], 1, 0);
      check(i == 3 ? "cal_rise" : "cal_low_after_accept", int'(cal), i == 3 ? 1 : 0);
      step();
    end
  endtask

  // monitor: pops the scoreboard whenever the DUT presents a sample
  always @(negedge clk) begin
    if (fv) begin
      fv_cnt++;
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL fv_unexpected: FiltValid seen at cycle %0d with no sample expected", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("fv_latency", cyc, e.due);
        for (int i = 0; i < 6; i++) check($sformatf("filt_axis%0d", i), int'(o_v[i]), int'($signed(e.v[i])));
      end
    end else if (q.size() != 0 && cyc > q[0].due) begin
      n_chk++;
      $display("FAIL fv_missing: no FiltValid by cycle %0d, expected at %0d", cyc, q[0].due);
      void'(q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int fv0;
    repeat (3) step();
    for (int i = 0; i < 6; i++) check("reset_out", int'(o_v[i]), 0);
    check("reset_cal", int'(cal), 0);
    check("reset_fv", int'(fv), 0);
    rst = 1'b0;
    step();

    // calibration: biasX = (100+102+98+100)/4 = 100
    cal_gx = '{100, 102, 98, 100};
    cal_gy = '{0, 0, 0, 0};
    cal_gz = '{0, 0, 0, 0};
    do_cal();
    check("no_fv_in_cal", fv_cnt, 0);

    // seed then one filter step
    expect6(0, 0, 16384, 50, 0, 0);
    send(0, 0, 16384, 150, 0, 0, 1, 1);
`ifdef IMU_IIR_EN
    expect6(-1, 0, 16384, 43, 0, 0);
`else
    expect6(-8, 0, 16384, 0, 0, 0);
`endif
    send(-8, 0, 16384, 100, 0, 0, 1, 1);
    step();

    // positive saturation, bias (3,-1000,0)
    do_recal();
    cal_gx = '{3, 3, 3, 4};
    cal_gy = '{-1000, -1000, -1000, -1000};
    cal_gz = '{0, 0, 0, 0};
    do_cal();
    expect6(0, 0, 0, -3, 131071, 0);
    send(0, 0, 0, 0, 131071, 0, 1, 1);
    step();

    // negative saturation, bias (0,1000,-1): -3>>>2 floors to -1
    do_recal();
    cal_gx = '{0, 0, 0, 0};
    cal_gy = '{998, 1002, 1001, 999};
    cal_gz = '{-1, -1, -1, 0};
    do_cal();
    expect6(0, 0, 0, 0, -131072, 1);
    send(0, 0, 0, 0, -131072, 0, 1, 1);
    step();

    // held-high DataValid gives one sample
    fv0 = fv_cnt;
`ifdef IMU_IIR_EN
    expect6(8, 0, 0, 0, -114688, 0);
`else
    expect6(64, 0, 0, 0, 0, 0);
`endif
    send(64, 0, 0, 0, 1000, -1, 20, 2);
    check("held_dv_one_fv", fv_cnt - fv0, 1);

    // toggling every 2 cycles gives one sample per rising edge
`ifdef IMU_IIR_EN
    expect6(15, 0, 0, 0, -100352, 0);
    send(64, 0, 0, 0, 1000, -1, 2, 2);
    expect6(21, 0, 0, 0, -87808, 0);
    send(64, 0, 0, 0, 1000, -1, 2, 2);
    expect6(26, 0, 0, 0, -76832, 0);
    send(64, 0, 0, 0, 1000, -1, 2, 2);
`else
    for (int k = 0; k < 3; k++) begin
      expect6(64, 0, 0, 0, 0, 0);
      send(64, 0, 0, 0, 1000, -1, 2, 2);
    end
`endif
    step();
    check("toggle_fv_count", fv_cnt - fv0, 4);

    // Recal coincident with accept: sample dropped, outputs held
    fv0 = fv_cnt;
    ax = 99; ay = 99; az = 99; gx = 99; gy = 99; gz = 99;
    dv = 1'b1;
    recal = 1'b1;
    step();
    check("recal_cal_low", int'(cal), 0);
    dv = 1'b0;
    recal = 1'b0;
    repeat (3) step();
    check("recal_no_fv", fv_cnt - fv0, 0);
    for (int i = 0; i < 6; i++) check("recal_hold", int'(o_v[i]), last_e[i]);
    cal_gx = '{0, 0, 0, 0};
    cal_gy = '{0, 0, 0, 0};
    cal_gz = '{0, 0, 0, 0};
    do_cal();
    check("recal_window_no_fv", fv_cnt - fv0, 0);
    expect6(1, 2, 3, 4, 5, 6);
    send(1, 2, 3, 4, 5, 6, 1, 1);
    step();
    step();

    // reset one cycle after an accept in RUN
    fv0 = fv_cnt;
    send(7, 7, 7, 7, 7, 7, 1, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) check("midreset_out", int'(o_v[i]), 0);
    check("midreset_cal", int'(cal), 0);
    check("midreset_fv", int'(fv), 0);
    repeat (3) step();
    check("midreset_no_fv", fv_cnt - fv0, 0);

    repeat (4) step();
    check("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
